// File: rtl/frame_sequencer.sv
// Frame sequencer: latches the selected animation and steps its frame index with a
// speed-selectable prescaler, supporting pause, single-step and one-shot playback.
module frame_sequencer #(
  parameter int BASE_DIV = 1000000,
  parameter int DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] animation,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       step,
  input  logic       oneshot,
  input  logic [4:0] limit,
  output logic [4:0] anim_sel,
  output logic [4:0] frame,
  output logic       frame_tick,
  output logic       wrap,
  output logic       done
);

  localparam logic [DIV_W-1:0] BASE_DIV_C = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] ONE_C      = DIV_W'(1);

  logic [4:0]       anim_sel_r, anim_nx_s;
  logic [4:0]       frame_r, frame_nx_s;
  logic [DIV_W-1:0] presc_r, presc_nx_s;
  logic             tick_r, tick_nx_s;
  logic             wrap_r, wrap_nx_s;
  logic             done_r, done_nx_s;

  logic [5:0]       lim_eff_s, last_s, frame_ext_s;
  logic [DIV_W-1:0] period_s, p_last_s;
  logic             change_s, step_adv_s, presc_adv_s, adv_s;

  // limit==0 stands for a full 32-frame animation
  assign lim_eff_s   = (limit == 5'd0) ? 6'd32 : {1'b0, limit};
  assign last_s      = lim_eff_s - 6'd1;
  assign frame_ext_s = {1'b0, frame_r};
  assign period_s    = BASE_DIV_C >> speed;
  assign p_last_s    = period_s - ONE_C;

  assign change_s    = (animation != anim_sel_r);
  assign step_adv_s  = pause && step && !done_r;
  assign presc_adv_s = !pause && !done_r && (presc_r >= p_last_s);
  assign adv_s       = !change_s && (step_adv_s || presc_adv_s);

  // Next-state for animation latch, prescaler, frame index and flags
  always_comb begin
    anim_nx_s  = anim_sel_r;
    frame_nx_s = frame_r;
    presc_nx_s = presc_r;
    done_nx_s  = done_r;
    tick_nx_s  = 1'b0;
    wrap_nx_s  = 1'b0;

    if (change_s) begin
      anim_nx_s  = animation;
      frame_nx_s = 5'd0;
      presc_nx_s = '0;
      done_nx_s  = 1'b0;
    end else if (done_r) begin
      presc_nx_s = '0;
      if (!oneshot) begin
        done_nx_s = 1'b0;
      end else begin
        done_nx_s = 1'b1;
      end
    end else if (pause) begin
      if (step) begin
        presc_nx_s = '0;
      end else begin
        presc_nx_s = presc_r;
      end
    end else begin
      if (presc_adv_s) begin
        presc_nx_s = '0;
      end else begin
        presc_nx_s = presc_r + ONE_C;
      end
    end

    // A frame beyond a shrunken limit always wraps, even in one-shot mode
    if (adv_s) begin
      tick_nx_s = 1'b1;
      if (frame_ext_s > last_s) begin
        frame_nx_s = 5'd0;
        wrap_nx_s  = 1'b1;
      end else if (frame_ext_s == last_s) begin
        if (oneshot) begin
          done_nx_s = 1'b1;
        end else begin
          frame_nx_s = 5'd0;
          wrap_nx_s  = 1'b1;
        end
      end else begin
        frame_nx_s = frame_r + 5'd1;
      end
    end else begin
      tick_nx_s = 1'b0;
    end
  end

  // State registers, updated only while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_sel_r <= 5'd0;
      frame_r    <= 5'd0;
      presc_r    <= '0;
      tick_r     <= 1'b0;
      wrap_r     <= 1'b0;
      done_r     <= 1'b0;
    end else if (ena) begin
      anim_sel_r <= anim_nx_s;
      frame_r    <= frame_nx_s;
      presc_r    <= presc_nx_s;
      tick_r     <= tick_nx_s;
      wrap_r     <= wrap_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign anim_sel   = anim_sel_r;
  assign frame      = frame_r;
  assign frame_tick = tick_r;
  assign wrap       = wrap_r;
  assign done       = done_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer (BASE_DIV=8).
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [4:0] animation;
  logic [2:0] speed;
  logic       pause;
  logic       step;
  logic       oneshot;
  logic [4:0] limit;
  logic [4:0] anim_sel;
  logic [4:0] frame;
  logic       frame_tick;
  logic       wrap;
  logic       done;

  int total = 0;
  int bad   = 0;

  frame_sequencer #(.BASE_DIV(8), .DIV_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .animation(animation), .speed(speed),
    .pause(pause), .step(step), .oneshot(oneshot), .limit(limit),
    .anim_sel(anim_sel), .frame(frame), .frame_tick(frame_tick), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until frame_tick is seen; -1 on timeout
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (frame_tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    logic [4:0] exp_f;
    rst_n = 1'b0; ena = 1'b1; animation = 5'd2; speed = 3'd0;
    pause = 1'b0; step = 1'b0; oneshot = 1'b0; limit = 5'd6;
    repeat (3) cyc();
    total++;
    if ({anim_sel, frame, frame_tick, wrap, done} !== 13'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {anim_sel, frame, frame_tick, wrap, done});
    end
    rst_n = 1'b1;
    cyc();
    total++;
    if (anim_sel !== 5'd2 || frame !== 5'd0 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL reset_latch anim_sel=%0d frame=%0d tick=%b want 2/0/0", anim_sel, frame, frame_tick);
    end
    for (int k = 1; k <= 6; k++) begin
      exp_f = (k == 6) ? 5'd0 : 5'(k);
      wait_tick(n);
      total++;
      if (n !== 8 || frame !== exp_f || wrap !== (k == 6)) begin
        bad++; $display("FAIL wrap_seq k=%0d period=%0d frame=%0d wrap=%b want 8/%0d/%b", k, n, frame, wrap, exp_f, (k == 6));
      end
    end
  endtask

  task automatic test_limit_encoding();
    int wraps;
    animation = 5'd28; limit = 5'd0; speed = 3'd3;
    cyc();
    total++;
    if (anim_sel !== 5'd28 || frame !== 5'd0 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL lim_change anim_sel=%0d frame=%0d tick=%b want 28/0/0", anim_sel, frame, frame_tick);
    end
    wraps = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (wrap) wraps++;
      if (k == 31) begin
        total++;
        if (frame !== 5'd31 || wrap !== 1'b0) begin
          bad++; $display("FAIL lim_31 frame=%0d wrap=%b want 31/0", frame, wrap);
        end
      end
    end
    total++;
    if (frame !== 5'd0 || wrap !== 1'b1 || wraps !== 1) begin
      bad++; $display("FAIL lim_wrap frame=%0d wrap=%b wraps=%0d want 0/1/1", frame, wrap, wraps);
    end
  endtask

  task automatic test_speed();
    int n;
    speed = 3'd2;
    for (int k = 0; k < 2; k++) begin
      wait_tick(n);
      total++;
      if (n !== 2) begin
        bad++; $display("FAIL speed2_period got=%0d want=2", n);
      end
    end
    speed = 3'd3;
    for (int k = 0; k < 2; k++) begin
      wait_tick(n);
      total++;
      if (n !== 1) begin
        bad++; $display("FAIL speed3_period got=%0d want=1", n);
      end
    end
  endtask

  task automatic test_pause_step();
    int errs;
    logic [4:0] exp_f;
    animation = 5'd2; limit = 5'd6; speed = 3'd3;
    repeat (4) cyc();
    total++;
    if (frame !== 5'd3) begin
      bad++; $display("FAIL pause_setup frame=%0d want=3", frame);
    end
    pause = 1'b1;
    errs = 0;
    repeat (100) begin
      cyc();
      if (frame !== 5'd3 || frame_tick !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL pause_hold bad_cycles=%0d want=0 frame=%0d", errs, frame);
    end
    for (int k = 1; k <= 3; k++) begin
      exp_f = (k == 3) ? 5'd0 : 5'(3 + k);
      step = 1'b1; cyc(); step = 1'b0;
      total++;
      if (frame !== exp_f || frame_tick !== 1'b1 || wrap !== (k == 3)) begin
        bad++; $display("FAIL step k=%0d frame=%0d tick=%b wrap=%b want %0d/1/%b", k, frame, frame_tick, wrap, exp_f, (k == 3));
      end
      cyc();
      total++;
      if (frame !== exp_f || frame_tick !== 1'b0) begin
        bad++; $display("FAIL step_idle k=%0d frame=%0d tick=%b want %0d/0", k, frame, frame_tick, exp_f);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_oneshot();
    animation = 5'd3; limit = 5'd5; speed = 3'd3; oneshot = 1'b1;
    cyc();
    repeat (4) cyc();
    total++;
    if (frame !== 5'd4 || done !== 1'b0) begin
      bad++; $display("FAIL os_last frame=%0d done=%b want 4/0", frame, done);
    end
    cyc();
    total++;
    if (frame !== 5'd4 || done !== 1'b1 || frame_tick !== 1'b1 || wrap !== 1'b0) begin
      bad++; $display("FAIL os_done frame=%0d done=%b tick=%b wrap=%b want 4/1/1/0", frame, done, frame_tick, wrap);
    end
    repeat (3) cyc();
    pause = 1'b1; step = 1'b1; cyc(); step = 1'b0; pause = 1'b0;
    total++;
    if (frame !== 5'd4 || done !== 1'b1 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL os_step_ignored frame=%0d done=%b tick=%b want 4/1/0", frame, done, frame_tick);
    end
    oneshot = 1'b0;
    cyc();
    total++;
    if (done !== 1'b0 || frame_tick !== 1'b0 || frame !== 5'd4) begin
      bad++; $display("FAIL os_clear done=%b tick=%b frame=%0d want 0/0/4", done, frame_tick, frame);
    end
    cyc();
    total++;
    if (frame !== 5'd0 || frame_tick !== 1'b1 || wrap !== 1'b1) begin
      bad++; $display("FAIL os_resume frame=%0d tick=%b wrap=%b want 0/1/1", frame, frame_tick, wrap);
    end
  endtask

  task automatic test_change_and_reset();
    animation = 5'd0; limit = 5'd16; speed = 3'd3;
    cyc();
    repeat (7) cyc();
    total++;
    if (anim_sel !== 5'd0 || frame !== 5'd7) begin
      bad++; $display("FAIL chg_setup anim_sel=%0d frame=%0d want 0/7", anim_sel, frame);
    end
    animation = 5'd1;
    cyc();
    total++;
    if (anim_sel !== 5'd1 || frame !== 5'd0 || frame_tick !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL chg_midrun anim_sel=%0d frame=%0d tick=%b wrap=%b want 1/0/0/0", anim_sel, frame, frame_tick, wrap);
    end
    repeat (4) cyc();
    speed = 3'd0;
    repeat (3) cyc();
    total++;
    if (frame !== 5'd4 || anim_sel !== 5'd1) begin
      bad++; $display("FAIL rst_setup frame=%0d anim_sel=%0d want 4/1", frame, anim_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({anim_sel, frame, frame_tick, wrap, done} !== 13'd0) begin
      bad++; $display("FAIL async_reset got=%h want=0", {anim_sel, frame, frame_tick, wrap, done});
    end
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_limit_encoding();
    test_speed();
    test_pause_step();
    test_oneshot();
    test_change_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
